crc_stream_engine: RTL and testbench

- Parametrised, frame-oriented CRC generator and checker. It is the successor to the team's fixed 8-bit/CRC-16 serial generator.
- Adds runtime-independent generics: width, polynomial, init, reflection, xorout and data width.
- Adds SOF/EOF framing, valid/ready handshakes on input and result, frame length count and drop count.
- Sits between the byte/word stream front-end and the packet formatter. It supplies CRC for TX and, optionally, a pass/fail check for RX.

---
 rtl/crc_stream_pkg.sv | 41 ++++
 rtl/crc_stream_engine_if.sv | 40 ++++
 rtl/crc_step.sv | 29 ++
 rtl/crc_stream_engine.sv | 149 ++++++++++++++
 tb/tb_crc_stream_engine.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/crc_stream_pkg.sv
// Shared types, presets and helpers for the CRC stream engine.
// Optional RX check feature is enabled by the CRC_STREAM_CHECK_EN macro.
package crc_stream_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] poly;
    logic [31:0] init;
    logic [31:0] xorout;
    logic        refin;
    logic        refout;
  } crc_preset_t;

  localparam crc_preset_t CRC16_XMODEM = '{
    poly: 32'h0000_1021, init: 32'h0000_0000, xorout: 32'h0000_0000,
    refin: 1'b0, refout: 1'b0};

  localparam crc_preset_t CRC16_CCITT_FALSE = '{
    poly: 32'h0000_1021, init: 32'h0000_FFFF, xorout: 32'h0000_0000,
    refin: 1'b0, refout: 1'b0};

  localparam crc_preset_t CRC32_ETH = '{
    poly: 32'h04C1_1DB7, init: 32'hFFFF_FFFF, xorout: 32'hFFFF_FFFF,
    refin: 1'b1, refout: 1'b1};

  // Reverse the low w bits of v; bits at and above w come back zero.
  function automatic logic [31:0] bit_reverse(input logic [31:0] v, input int unsigned w);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < w) r[5'(i)] = v[5'(w - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/crc_stream_engine_if.sv
// Stream-in / result-out bundle for crc_stream_engine.
// out_ok exists only when CRC_STREAM_CHECK_EN is defined.
interface crc_stream_engine_if #(
  parameter int unsigned CRC_W  = 16,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LEN_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_sof;
  logic              in_eof;
  logic              out_valid;
  logic              out_ready;
  logic [CRC_W-1:0]  out_crc;
  logic [LEN_W-1:0]  out_len;
  logic              out_abort;
  logic [7:0]        drop_cnt;
`ifdef CRC_STREAM_CHECK_EN
  logic              out_ok;

  modport slave (
    input  in_valid, in_data, in_sof, in_eof, out_ready,
    output in_ready, out_valid, out_crc, out_len, out_abort, drop_cnt, out_ok
  );
  modport master (
    output in_valid, in_data, in_sof, in_eof, out_ready,
    input  in_ready, out_valid, out_crc, out_len, out_abort, drop_cnt, out_ok
  );
`else
  modport slave (
    input  in_valid, in_data, in_sof, in_eof, out_ready,
    output in_ready, out_valid, out_crc, out_len, out_abort, drop_cnt
  );
  modport master (
    output in_valid, in_data, in_sof, in_eof, out_ready,
    input  in_ready, out_valid, out_crc, out_len, out_abort, drop_cnt
  );
`endif
endinterface

// File: rtl/crc_step.sv
// Combinational CRC update: folds one DATA_W word into the register, MSB first.
module crc_step #(
  parameter int unsigned          CRC_W  = 16,
  parameter logic [CRC_W-1:0]     POLY   = CRC_W'(16'h1021),
  parameter int unsigned          DATA_W = 8
) (
  input  logic [CRC_W-1:0]  reg_in,
  input  logic [DATA_W-1:0] data,
  output logic [CRC_W-1:0]  next
);

  logic [CRC_W-1:0]  r;
  logic [DATA_W-1:0] d;
  logic              fb;

  // Bit-serial LFSR unrolled across the word.
  always_comb begin
    r  = reg_in;
    d  = data;
    fb = 1'b0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      fb = r[CRC_W-1] ^ d[DATA_W-1];
      r  = {r[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
      d  = d << 1;
    end
    next = r;
  end

endmodule

// File: rtl/crc_stream_engine.sv
// Frame-oriented CRC generator with SOF/EOF framing and valid/ready result.
// Define CRC_STREAM_CHECK_EN to add the RESIDUE parameter and out_ok check.
module crc_stream_engine
  import crc_stream_pkg::*;
#(
  parameter int unsigned      CRC_W   = 16,
  parameter logic [CRC_W-1:0] POLY    = CRC_W'(16'h1021),
  parameter logic [CRC_W-1:0] INIT    = '0,
  parameter logic [CRC_W-1:0] XOROUT  = '0,
  parameter bit               REFIN   = 1'b0,
  parameter bit               REFOUT  = 1'b0,
  parameter int unsigned      DATA_W  = 8,
  parameter int unsigned      LEN_W   = 16
`ifdef CRC_STREAM_CHECK_EN
  ,
  parameter logic [CRC_W-1:0] RESIDUE = '0
`endif
) (
  input logic                clk,
  input logic                rst,
  crc_stream_engine_if.slave bus
);

  state_t             state_q, state_d;
  logic [CRC_W-1:0]   crc_q, crc_d;
  logic [CRC_W-1:0]   out_crc_q, out_crc_d;
  logic [LEN_W-1:0]   len_q, len_d, len_inc;
  logic               abort_q, abort_d;
  logic [7:0]         drop_q, drop_d;
  logic [CRC_W-1:0]   step_base, step_next, crc_fin;
  logic [DATA_W-1:0]  step_data;
  logic               ready, xfer, latch;
`ifdef CRC_STREAM_CHECK_EN
  logic               ok_q, ok_d;
`endif

  assign ready     = (state_q != DONE);
  assign xfer      = bus.in_valid & ready;
  // A SOF (or any accepted word in IDLE) starts from INIT, otherwise continue.
  assign step_base = ((state_q == IDLE) || bus.in_sof) ? INIT : crc_q;
  assign step_data = REFIN ? DATA_W'(bit_reverse(32'(bus.in_data), DATA_W)) : bus.in_data;
  assign len_inc   = (len_q == '1) ? len_q : len_q + LEN_W'(1);
  // Final value is formed from the post-step register so it can be latched on the EOF edge.
  assign crc_fin   = (REFOUT ? CRC_W'(bit_reverse(32'(step_next), CRC_W)) : step_next) ^ XOROUT;

  crc_step #(
    .CRC_W (CRC_W),
    .POLY  (POLY),
    .DATA_W(DATA_W)
  ) u_step (
    .reg_in(step_base),
    .data  (step_data),
    .next  (step_next)
  );

  // Next-state, register update and result latch.
  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    len_d     = len_q;
    abort_d   = abort_q;
    drop_d    = drop_q;
    out_crc_d = out_crc_q;
    latch     = 1'b0;
`ifdef CRC_STREAM_CHECK_EN
    ok_d      = ok_q;
`endif
    case (state_q)
      IDLE: begin
        if (xfer) begin
          if (bus.in_sof) begin
            crc_d   = step_next;
            len_d   = LEN_W'(1);
            abort_d = 1'b0;
            if (bus.in_eof) begin
              state_d = DONE;
              latch   = 1'b1;
            end else begin
              state_d = BUSY;
            end
          end else if (drop_q != '1) begin
            drop_d = drop_q + 8'd1;
          end
        end
      end
      BUSY: begin
        if (xfer) begin
          crc_d = step_next;
          if (bus.in_sof) begin
            len_d   = LEN_W'(1);
            abort_d = 1'b1;
          end else begin
            len_d = len_inc;
          end
          if (bus.in_eof) begin
            state_d = DONE;
            latch   = 1'b1;
          end
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (latch) begin
      out_crc_d = crc_fin;
`ifdef CRC_STREAM_CHECK_EN
      ok_d      = (step_next == RESIDUE);
`endif
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      crc_q     <= INIT;
      len_q     <= '0;
      abort_q   <= 1'b0;
      drop_q    <= '0;
      out_crc_q <= '0;
`ifdef CRC_STREAM_CHECK_EN
      ok_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      len_q     <= len_d;
      abort_q   <= abort_d;
      drop_q    <= drop_d;
      out_crc_q <= out_crc_d;
`ifdef CRC_STREAM_CHECK_EN
      ok_q      <= ok_d;
`endif
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_crc   = out_crc_q;
  assign bus.out_len   = len_q;
  assign bus.out_abort = abort_q;
  assign bus.drop_cnt  = drop_q;
`ifdef CRC_STREAM_CHECK_EN
  assign bus.out_ok    = ok_q;
`endif

endmodule

// File: tb/tb_crc_stream_engine.sv
// Bench for crc_stream_engine: three instances (XMODEM, CCITT-FALSE with 4-bit
// length counter, CRC-32/ETH) share one byte stream. Reference CRC is computed
// by polynomial long division. Define CRC_STREAM_CHECK_EN to also check out_ok.
module tb_crc_stream_engine;
  import crc_stream_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_sof, in_eof, out_ready;
  logic [7:0] in_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  crc_stream_engine_if #(.CRC_W(16), .DATA_W(8), .LEN_W(16)) if0 ();
  crc_stream_engine_if #(.CRC_W(16), .DATA_W(8), .LEN_W(4))  if1 ();
  crc_stream_engine_if #(.CRC_W(32), .DATA_W(8), .LEN_W(16)) if2 ();

  assign if0.in_valid = in_valid;  assign if0.in_data = in_data;
  assign if0.in_sof   = in_sof;    assign if0.in_eof  = in_eof;
  assign if0.out_ready = out_ready;
  assign if1.in_valid = in_valid;  assign if1.in_data = in_data;
  assign if1.in_sof   = in_sof;    assign if1.in_eof  = in_eof;
  assign if1.out_ready = out_ready;
  assign if2.in_valid = in_valid;  assign if2.in_data = in_data;
  assign if2.in_sof   = in_sof;    assign if2.in_eof  = in_eof;
  assign if2.out_ready = out_ready;

  crc_stream_engine #(
    .CRC_W(16), .POLY(CRC16_XMODEM.poly[15:0]), .INIT(CRC16_XMODEM.init[15:0]),
    .XOROUT(CRC16_XMODEM.xorout[15:0]), .REFIN(CRC16_XMODEM.refin),
    .REFOUT(CRC16_XMODEM.refout), .DATA_W(8), .LEN_W(16)
  ) u0 (.clk(clk), .rst(rst), .bus(if0));

  crc_stream_engine #(
    .CRC_W(16), .POLY(CRC16_CCITT_FALSE.poly[15:0]), .INIT(CRC16_CCITT_FALSE.init[15:0]),
    .XOROUT(CRC16_CCITT_FALSE.xorout[15:0]), .REFIN(CRC16_CCITT_FALSE.refin),
    .REFOUT(CRC16_CCITT_FALSE.refout), .DATA_W(8), .LEN_W(4)
  ) u1 (.clk(clk), .rst(rst), .bus(if1));

  crc_stream_engine #(
    .CRC_W(32), .POLY(CRC32_ETH.poly), .INIT(CRC32_ETH.init),
    .XOROUT(CRC32_ETH.xorout), .REFIN(CRC32_ETH.refin),
    .REFOUT(CRC32_ETH.refout), .DATA_W(8), .LEN_W(16)
  ) u2 (.clk(clk), .rst(rst), .bus(if2));

  // ---------------- reference model ----------------
  // Remainder of (init*x^N + M*x^W) mod (x^W + poly), by long division on a bit queue.
  function automatic logic [31:0] ref_raw(input int w, input logic [31:0] poly,
                                          input logic [31:0] init, input bit refin,
                                          input logic [7:0] m[$]);
    bit q[$];
    logic [31:0] r;
    r = '0;
    foreach (m[i]) begin
      for (int k = 0; k < 8; k++) q.push_back(refin ? m[i][k] : m[i][7-k]);
    end
    for (int k = 0; k < w; k++) q.push_back(1'b0);
    for (int k = 0; k < w; k++) q[k] = q[k] ^ init[w-1-k];
    for (int i = 0; i + w < q.size(); i++) begin
      if (q[i]) begin
        q[i] = 1'b0;
        for (int j = 0; j < w; j++) q[i+1+j] = q[i+1+j] ^ poly[w-1-j];
      end
    end
    for (int j = 0; j < w; j++) r[w-1-j] = q[q.size()-w+j];
    return r;
  endfunction

  function automatic logic [31:0] ref_crc(input int w, input crc_preset_t p, input logic [7:0] m[$]);
    logic [31:0] raw, o;
    raw = ref_raw(w, p.poly, p.init, p.refin, m);
    o = raw;
    if (p.refout) begin
      o = '0;
      for (int k = 0; k < w; k++) o[k] = raw[w-1-k];
    end
    return (o ^ p.xorout) & ((w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1));
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] m[$], input bit gaps);
    for (int i = 0; i < m.size(); i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        in_sof   = 1'($urandom_range(0, 1));
        in_eof   = 1'($urandom_range(0, 1));
        in_data  = 8'($urandom);
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = m[i];
      in_sof   = (i == 0);
      in_eof   = (i == m.size() - 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_eof   = 1'b0;
  endtask

  logic [15:0] r0_crc, r1_crc;
  logic [31:0] r2_crc;
  logic [15:0] r0_len;
  logic [3:0]  r1_len;
  logic        r0_abort, r0_ok, got;

  task automatic collect();
    int n = 0;
    got = 1'b0;
    while (!if0.out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!if0.out_valid) begin
      checks++;
      failures++;
      $display("FAIL collect_timeout: out_valid got 0 expected 1 within 40 cycles");
      return;
    end
    got      = 1'b1;
    r0_crc   = if0.out_crc;
    r0_len   = if0.out_len;
    r0_abort = if0.out_abort;
    r1_crc   = if1.out_crc;
    r1_len   = if1.out_len;
    r2_crc   = if2.out_crc;
`ifdef CRC_STREAM_CHECK_EN
    r0_ok    = if0.out_ok;
`else
    r0_ok    = 1'b0;
`endif
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  typedef struct {
    int          n;
    logic [7:0]  b[20];
    logic [15:0] e0;
    logic [15:0] e1;
    logic [31:0] e2;
    logic        ok;
  } vec_t;

  localparam int NV = 7;
  vec_t tbl[NV];
  logic [7:0] msg[$];
  logic [7:0] base_drop;
  logic [15:0] hold_crc;

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin : main
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
    in_data = '0; out_ready = 1'b0;

    // ---- vector table ----
    for (int v = 0; v < NV; v++) begin
      tbl[v].n = 0;
      for (int k = 0; k < 20; k++) tbl[v].b[k] = '0;
    end
    tbl[0].n = 9;  for (int k = 0; k < 9; k++) tbl[0].b[k] = 8'h31 + 8'(k);
    tbl[1].n = 1;  tbl[1].b[0] = 8'h00;
    tbl[2].n = 1;  tbl[2].b[0] = 8'hFF;
    tbl[3].n = 2;  tbl[3].b[0] = 8'h80; tbl[3].b[1] = 8'h01;
    tbl[4].n = 11; for (int k = 0; k < 9; k++) tbl[4].b[k] = 8'h31 + 8'(k);
    tbl[4].b[9] = 8'h31; tbl[4].b[10] = 8'hC3;
    tbl[5] = tbl[4]; tbl[5].b[4] = 8'h34;
    tbl[6].n = 20; for (int k = 0; k < 20; k++) tbl[6].b[k] = 8'(k * 7 + 3);
    for (int v = 0; v < NV; v++) begin
      msg = {};
      for (int k = 0; k < tbl[v].n; k++) msg.push_back(tbl[v].b[k]);
      tbl[v].e0 = 16'(ref_crc(16, CRC16_XMODEM, msg));
      tbl[v].e1 = 16'(ref_crc(16, CRC16_CCITT_FALSE, msg));
      tbl[v].e2 = ref_crc(32, CRC32_ETH, msg);
      tbl[v].ok = (ref_raw(16, CRC16_XMODEM.poly, CRC16_XMODEM.init, 1'b0, msg) == 32'd0);
    end
    tbl[0].e0 = 16'h31C3; tbl[0].e1 = 16'h29B1; tbl[0].e2 = 32'hCBF4_3926;
    tbl[4].ok = 1'b1; tbl[5].ok = 1'b0;

    // ---- reset state ----
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(if0.in_ready), 32'd1);
    chk("rst_out_valid", 32'(if0.out_valid), 32'd0);
    chk("rst_out_crc", 32'(if0.out_crc), 32'd0);
    chk("rst_out_len", 32'(if0.out_len), 32'd0);
    chk("rst_out_abort", 32'(if0.out_abort), 32'd0);
    chk("rst_drop_cnt", 32'(if0.drop_cnt), 32'd0);

    // ---- table-driven frames ----
    for (int v = 0; v < NV; v++) begin
      msg = {};
      for (int k = 0; k < tbl[v].n; k++) msg.push_back(tbl[v].b[k]);
      send_frame(msg, 1'b0);
      chk($sformatf("v%0d_latency", v), 32'(if0.out_valid), 32'd1);
      collect();
      if (got) begin
        chk($sformatf("v%0d_crc0", v), 32'(r0_crc), 32'(tbl[v].e0));
        chk($sformatf("v%0d_crc1", v), 32'(r1_crc), 32'(tbl[v].e1));
        chk($sformatf("v%0d_crc2", v), r2_crc, tbl[v].e2);
        chk($sformatf("v%0d_len0", v), 32'(r0_len), 32'(tbl[v].n));
        chk($sformatf("v%0d_len1_sat", v), 32'(r1_len), (tbl[v].n > 15) ? 32'd15 : 32'(tbl[v].n));
        chk($sformatf("v%0d_abort", v), 32'(r0_abort), 32'd0);
`ifdef CRC_STREAM_CHECK_EN
        chk($sformatf("v%0d_ok", v), 32'(r0_ok), 32'(tbl[v].ok));
`endif
        chk($sformatf("v%0d_valid_drop", v), 32'(if0.out_valid), 32'd0);
      end
    end

    // ---- restart by SOF mid-frame ----
    msg = {8'hDE, 8'hAD, 8'hBE};
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = msg[i]; in_sof = (i == 0); in_eof = 1'b0;
      @(negedge clk);
    end
    chk("abort_no_early_result", 32'(if0.out_valid), 32'd0);
    msg = {8'h12, 8'h34};
    send_frame(msg, 1'b0);
    collect();
    if (got) begin
      chk("abort_len", 32'(r0_len), 32'd2);
      chk("abort_flag", 32'(r0_abort), 32'd1);
      chk("abort_crc", 32'(r0_crc), ref_crc(16, CRC16_XMODEM, msg));
      chk("abort_crc32", r2_crc, ref_crc(32, CRC32_ETH, msg));
    end
    msg = {8'h77};
    send_frame(msg, 1'b0);
    collect();
    if (got) chk("abort_cleared", 32'(r0_abort), 32'd0);

    // ---- DONE holds with out_ready low and input pressure ----
    msg = {8'h5A};
    send_frame(msg, 1'b0);
    hold_crc = 16'(ref_crc(16, CRC16_XMODEM, msg));
    in_valid = 1'b1; in_sof = 1'b1; in_eof = 1'b1; in_data = 8'hC7;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("hold%0d_in_ready", c), 32'(if0.in_ready), 32'd0);
      chk($sformatf("hold%0d_out_valid", c), 32'(if0.out_valid), 32'd1);
      chk($sformatf("hold%0d_out_crc", c), 32'(if0.out_crc), 32'(hold_crc));
    end
    in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
    collect();
    if (got) begin
      chk("hold_final_crc", 32'(r0_crc), 32'(hold_crc));
      chk("hold_final_len", 32'(r0_len), 32'd1);
    end

    // ---- drops in IDLE, including saturation ----
    base_drop = if0.drop_cnt;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_sof = 1'b0; in_eof = (i == 1); in_data = 8'(i);
      @(negedge clk);
    end
    in_valid = 1'b0; in_eof = 1'b0;
    @(negedge clk);
    chk("drop_inc3", 32'(if0.drop_cnt), 32'(base_drop) + 32'd3);
    chk("drop_no_result", 32'(if0.out_valid), 32'd0);
    in_valid = 1'b1;
    repeat (300) @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("drop_saturate", 32'(if0.drop_cnt), 32'd255);

    // ---- reset while BUSY ----
    msg = {8'h01, 8'h02, 8'h03, 8'h04};
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = msg[i]; in_sof = (i == 0); in_eof = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(if0.out_valid), 32'd0);
    chk("midrst_out_len", 32'(if0.out_len), 32'd0);
    chk("midrst_drop_cnt", 32'(if0.drop_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", 32'(if0.in_ready), 32'd1);
    chk("midrst_out_crc", 32'(if0.out_crc), 32'd0);
    msg = {};
    for (int k = 0; k < 9; k++) msg.push_back(8'h31 + 8'(k));
    send_frame(msg, 1'b0);
    collect();
    if (got) chk("midrst_next_crc", 32'(r0_crc), 32'h31C3);

    // ---- randomized frames vs reference model ----
    for (int f = 0; f < 25; f++) begin
      int n;
      n = int'($urandom_range(1, 16));
      msg = {};
      for (int k = 0; k < n; k++) msg.push_back(8'($urandom));
      send_frame(msg, 1'b1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      collect();
      if (got) begin
        chk($sformatf("rnd%0d_crc0", f), 32'(r0_crc), ref_crc(16, CRC16_XMODEM, msg));
        chk($sformatf("rnd%0d_crc2", f), r2_crc, ref_crc(32, CRC32_ETH, msg));
        chk($sformatf("rnd%0d_len", f), 32'(r0_len), 32'(n));
        chk($sformatf("rnd%0d_abort", f), 32'(r0_abort), 32'd0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
